// File: rtl/aes_pkg.sv
// Shared types and constants for the AES host sequencer.
`default_nettype none

package aes_pkg;

  localparam int AES_BLOCK_W    = 128;
  localparam int AES_WORD_W     = 32;
  localparam int AES_LOAD_WORDS = 8;
  localparam int AES_READ_WORDS = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_DONE = 3'd2,
    READ_REQ  = 3'd3,
    READ_WAIT = 3'd4,
    CAPTURE   = 3'd5,
    OUT       = 3'd6
  } aes_seq_state_t;

  // Word idx of the 8-word load stream {plaintext words 0..3, key words 0..3}.
  function automatic logic [AES_WORD_W-1:0] load_word(
    input logic [AES_BLOCK_W-1:0] pt,
    input logic [AES_BLOCK_W-1:0] key,
    input logic [2:0]             idx
  );
    logic [2*AES_BLOCK_W-1:0] cat;
    cat = {pt, key};
    return cat[(2*AES_BLOCK_W-1) - AES_WORD_W*int'(idx) -: AES_WORD_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_host_seq_if.sv
// Request/result stream plus word-serial AES core port, bundled for the sequencer.
`default_nettype none

interface aes_host_seq_if;

  logic                            s_valid;
  logic                            s_ready;
  logic [aes_pkg::AES_BLOCK_W-1:0] s_plaintext;
  logic [aes_pkg::AES_BLOCK_W-1:0] s_key;
  logic                            m_valid;
  logic                            m_ready;
  logic [aes_pkg::AES_BLOCK_W-1:0] m_ciphertext;
  logic                            m_error;
  logic                            busy;
  logic                            aes_start_n;
  logic [aes_pkg::AES_WORD_W-1:0]  aes_dword_in;
  logic                            aes_start_read_n;
  logic [aes_pkg::AES_WORD_W-1:0]  aes_dword_out;
  logic                            aes_done;

  modport master (
    input  s_valid, s_plaintext, s_key, m_ready, aes_dword_out, aes_done,
    output s_ready, m_valid, m_ciphertext, m_error, busy,
           aes_start_n, aes_dword_in, aes_start_read_n
  );

  modport slave (
    output s_valid, s_plaintext, s_key, m_ready, aes_dword_out, aes_done,
    input  s_ready, m_valid, m_ciphertext, m_error, busy,
           aes_start_n, aes_dword_in, aes_start_read_n
  );

endinterface

`default_nettype wire

// File: rtl/aes_host_seq.sv
// Host-side sequencer: loads one pt/key pair into the word-serial AES core,
// waits for done (with watchdog), reads back and presents the 128-bit result.
`default_nettype none

module aes_host_seq
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int READ_LAT       = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  aes_host_seq_if.master bus
);

  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LAT_W = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((READ_LAT > 1) ? READ_LAT - 2 : 0);

  aes_seq_state_t state;
  aes_seq_state_t next_state;

  logic [2:0]             idx;
  logic [WD_W-1:0]        wd_cnt;
  logic [LAT_W-1:0]       lat_cnt;
  logic [1:0]             cap_idx;
  logic [AES_BLOCK_W-1:0] pt_lat;
  logic [AES_BLOCK_W-1:0] key_lat;
  logic [AES_BLOCK_W-1:0] ct_q;
  logic                   err_q;
  logic                   start_n_q;
  logic                   start_read_n_q;
  logic [AES_WORD_W-1:0]  dword_in_q;
  logic                   wd_expired;

  assign wd_expired = (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (bus.s_valid)       next_state = LOAD;
      LOAD:      if (idx == 3'd7)       next_state = WAIT_DONE;
      WAIT_DONE: begin
        // done wins over the watchdog on the final cycle
        if (bus.aes_done)               next_state = READ_REQ;
        else if (wd_expired)            next_state = OUT;
      end
      READ_REQ:                         next_state = (READ_LAT == 1) ? CAPTURE : READ_WAIT;
      READ_WAIT: if (lat_cnt == LAT_LAST) next_state = CAPTURE;
      CAPTURE:   if (cap_idx == 2'd3)   next_state = OUT;
      OUT:       if (bus.m_ready)       next_state = IDLE;
      default:                          next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready          = (state == IDLE);
    bus.busy             = (state != IDLE);
    bus.m_valid          = (state == OUT);
    bus.m_ciphertext     = ct_q;
    bus.m_error          = err_q;
    bus.aes_start_n      = start_n_q;
    bus.aes_start_read_n = start_read_n_q;
    bus.aes_dword_in     = dword_in_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx            <= '0;
      wd_cnt         <= '0;
      lat_cnt        <= '0;
      cap_idx        <= '0;
      pt_lat         <= '0;
      key_lat        <= '0;
      ct_q           <= '0;
      err_q          <= 1'b0;
      start_n_q      <= 1'b1;
      start_read_n_q <= 1'b1;
      dword_in_q     <= '0;
    end else begin
      start_n_q      <= 1'b1;
      start_read_n_q <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.s_valid) begin
            pt_lat     <= bus.s_plaintext;
            key_lat    <= bus.s_key;
            idx        <= 3'd0;
            dword_in_q <= bus.s_plaintext[AES_BLOCK_W-1 -: AES_WORD_W];
            start_n_q  <= 1'b0;
          end
        end
        LOAD: begin
          if (idx == 3'd7) begin
            dword_in_q <= '0;
            wd_cnt     <= '0;
          end else begin
            idx        <= idx + 3'd1;
            dword_in_q <= load_word(pt_lat, key_lat, idx + 3'd1);
          end
        end
        WAIT_DONE: begin
          if (bus.aes_done) begin
            start_read_n_q <= 1'b0;
          end else if (wd_expired) begin
            err_q <= 1'b1;
            ct_q  <= '0;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        READ_REQ: begin
          lat_cnt <= '0;
          cap_idx <= '0;
        end
        READ_WAIT: begin
          lat_cnt <= lat_cnt + LAT_W'(1);
        end
        CAPTURE: begin
          // four shifts leave word0 in the top dword
          ct_q    <= {ct_q[AES_BLOCK_W-AES_WORD_W-1:0], bus.aes_dword_out};
          cap_idx <= cap_idx + 2'd1;
          if (cap_idx == 2'd3) err_q <= 1'b0;
        end
        OUT: begin
          if (bus.m_ready) err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_host_seq.sv
// Self-checking bench: two sequencers (default params; TIMEOUT 16 / READ_LAT 3),
// each driving a behavioural AES-128 core model.
`default_nettype none

module tb_aes_host_seq;

  localparam logic [127:0] NIST_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] NIST_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] NIST_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [1:0]   s_valid = '0;
  logic [1:0]   m_ready = '0;
  logic [127:0] pt_in  [2];
  logic [127:0] key_in [2];
  logic [1:0]   s_ready, m_valid, m_error, busy, start_n, start_read_n;
  logic [127:0] m_ct     [2];
  logic [31:0]  dword_in [2];

  int          done_dly [2];
  bit          stub_en  [2];
  logic [31:0] stub_w   [4];

  // ---------------- AES-128 reference (FIPS-197 arithmetic) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r = r ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, r, s;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row + 4*c] = sbox(s[row + 4*((c + row) % 4)]);
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r != 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- DUTs with behavioural cores ----------------
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int TO = (g == 0) ? 256 : 16;
    localparam int RL = (g == 0) ? 1 : 3;

    aes_host_seq_if bus ();

    aes_host_seq #(.TIMEOUT_CYCLES(TO), .READ_LAT(RL)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
    );

    assign bus.s_valid     = s_valid[g];
    assign bus.s_plaintext = pt_in[g];
    assign bus.s_key       = key_in[g];
    assign bus.m_ready     = m_ready[g];
    assign s_ready[g]      = bus.s_ready;
    assign m_valid[g]      = bus.m_valid;
    assign m_error[g]      = bus.m_error;
    assign busy[g]         = bus.busy;
    assign start_n[g]      = bus.aes_start_n;
    assign start_read_n[g] = bus.aes_start_read_n;
    assign m_ct[g]         = bus.m_ciphertext;
    assign dword_in[g]     = bus.aes_dword_in;

    int          ld_cnt    = 8;
    int          dly_cnt   = -1;
    int          rd_t      = -1;
    int          rd_pulses = 0;
    logic [31:0] ld_w  [8];
    logic [31:0] res_w [4];
    logic        done_r = 1'b0;
    logic [31:0] dout   = 32'h0;

    assign bus.aes_done      = done_r;
    assign bus.aes_dword_out = dout;

    always @(posedge clk) begin : core
      int tt;
      int j;
      logic [127:0] r;
      if (!bus.aes_start_n) begin
        ld_w[0] = bus.aes_dword_in;
        ld_cnt  = 1;
        dly_cnt = -1;
        rd_t    = -1;
        done_r <= 1'b0;
      end else if (ld_cnt < 8) begin
        ld_w[ld_cnt] = bus.aes_dword_in;
        ld_cnt++;
        if (ld_cnt == 8) begin
          r = stub_en[g] ? {stub_w[0], stub_w[1], stub_w[2], stub_w[3]}
                         : aes_enc({ld_w[0], ld_w[1], ld_w[2], ld_w[3]},
                                   {ld_w[4], ld_w[5], ld_w[6], ld_w[7]});
          for (int i = 0; i < 4; i++) res_w[i] = r[127-32*i -: 32];
          dly_cnt = done_dly[g];
        end
      end else if (dly_cnt > 0) begin
        dly_cnt--;
      end
      if (dly_cnt == 0) begin
        done_r <= 1'b1;
        dly_cnt = -1;
      end
      if (!bus.aes_start_read_n) begin
        tt = 0;
        rd_pulses++;
        done_r <= 1'b0;
      end else begin
        tt = rd_t;
      end
      // word j is driven so that it is sampled READ_LAT+j edges after the read pulse
      if (tt >= 0) begin
        j = tt - (RL - 1);
        dout <= (j >= 0 && j < 4) ? res_w[j] : 32'hdeadbeef;
        rd_t = (tt < RL + 3) ? tt + 1 : -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int u, input logic [127:0] p, input logic [127:0] k, output bit ok);
    int n = 0;
    @(negedge clk);
    s_valid[u] = 1'b1;
    pt_in[u]   = p;
    key_in[u]  = k;
    while (!s_ready[u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = s_ready[u];
    @(posedge clk);
    #1 s_valid[u] = 1'b0;
  endtask

  task automatic wait_valid(input int u, input int maxc, output int cyc, output bit ok);
    cyc = 0;
    while (!m_valid[u] && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    ok = m_valid[u];
  endtask

  task automatic consume(input int u);
    m_ready[u] = 1'b1;
    @(posedge clk);
    #1 m_ready[u] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      total++;
      if ({s_ready[u], busy[u], m_valid[u], m_error[u], start_n[u], start_read_n[u]} !== 6'b100011) begin
        bad++;
        $display("FAIL reset_ctrl[%0d]: got %b want 100011", u,
                 {s_ready[u], busy[u], m_valid[u], m_error[u], start_n[u], start_read_n[u]});
      end
      total++;
      if (m_ct[u] !== 128'h0) begin
        bad++;
        $display("FAIL reset_ct[%0d]: got %h want 0", u, m_ct[u]);
      end
      total++;
      if (dword_in[u] !== 32'h0) begin
        bad++;
        $display("FAIL reset_dword_in[%0d]: got %h want 0", u, dword_in[u]);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nist_load();
    logic [255:0] cat;
    logic [31:0]  exp_w;
    bit           ok;
    int           cyc;
    cat = {NIST_PT, NIST_KEY};
    done_dly[0] = 4;
    m_ready[0]  = 1'b1;
    send(0, NIST_PT, NIST_KEY, ok);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_w = cat[255-32*k -: 32];
      total++;
      if (dword_in[0] !== exp_w || start_n[0] !== (k != 0)) begin
        bad++;
        $display("FAIL nist_load[%0d]: got %h/start_n=%b want %h/start_n=%b",
                 k, dword_in[0], start_n[0], exp_w, (k != 0));
      end
    end
    @(negedge clk);
    total++;
    if (dword_in[0] !== 32'h0) begin
      bad++;
      $display("FAIL nist_load_end: got %h want 0", dword_in[0]);
    end
    wait_valid(0, 300, cyc, ok);
    total++;
    if (!ok || m_ct[0] !== NIST_CT || m_error[0] !== 1'b0) begin
      bad++;
      $display("FAIL nist_result: got valid=%b ct=%h err=%b want valid=1 ct=%h err=0",
               ok, m_ct[0], m_error[0], NIST_CT);
    end
    @(posedge clk);
    #1 m_ready[0] = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [127:0] p, k, exp_ct;
    bit ok;
    int cyc;
    p = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    exp_ct = aes_enc(p, k);
    done_dly[0] = int'($urandom_range(0, 6));
    m_ready[0]  = 1'b0;
    send(0, p, k, ok);
    wait_valid(0, 300, cyc, ok);
    for (int i = 0; i < 20; i++) begin
      total++;
      if (m_valid[0] !== 1'b1 || m_ct[0] !== exp_ct || s_ready[0] !== 1'b0) begin
        bad++;
        $display("FAIL backpressure[%0d]: got valid=%b ct=%h s_ready=%b want 1/%h/0",
                 i, m_valid[0], m_ct[0], s_ready[0], exp_ct);
      end
      @(negedge clk);
    end
    m_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    m_ready[0] = 1'b0;
    total++;
    if (m_valid[0] !== 1'b0 || s_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL bp_accept: got valid=%b s_ready=%b want 0/1", m_valid[0], s_ready[0]);
    end
  endtask

  task automatic test_read_latency();
    bit ok;
    int cyc;
    stub_en[1]  = 1'b1;
    stub_w[0]   = 32'h11111111;
    stub_w[1]   = 32'h22222222;
    stub_w[2]   = 32'h33333333;
    stub_w[3]   = 32'h44444444;
    done_dly[1] = 2;
    send(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, ok);
    wait_valid(1, 200, cyc, ok);
    total++;
    if (!ok || m_ct[1] !== 128'h11111111222222223333333344444444 || m_error[1] !== 1'b0) begin
      bad++;
      $display("FAIL read_lat3: got valid=%b ct=%h err=%b want 1/11111111222222223333333344444444/0",
               ok, m_ct[1], m_error[1]);
    end
    consume(1);
    stub_en[1] = 1'b0;
  endtask

  task automatic test_watchdog();
    bit ok;
    int cyc, p0;
    done_dly[1] = -1;
    p0 = g_dut[1].rd_pulses;
    send(1, NIST_PT, NIST_KEY, ok);
    wait_valid(1, 100, cyc, ok);
    // 8 LOAD cycles + 16 WAIT_DONE cycles, OUT in cycle 25 after acceptance
    total++;
    if (!ok || cyc != 25) begin
      bad++;
      $display("FAIL watchdog_time: got valid=%b at cycle %0d want cycle 25", ok, cyc);
    end
    total++;
    if (m_error[1] !== 1'b1 || m_ct[1] !== 128'h0) begin
      bad++;
      $display("FAIL watchdog_out: got err=%b ct=%h want 1/0", m_error[1], m_ct[1]);
    end
    total++;
    if (g_dut[1].rd_pulses != p0) begin
      bad++;
      $display("FAIL watchdog_read: got %0d read pulses want 0", g_dut[1].rd_pulses - p0);
    end
    consume(1);
    total++;
    if (m_error[1] !== 1'b0 || s_ready[1] !== 1'b1) begin
      bad++;
      $display("FAIL watchdog_clear: got err=%b s_ready=%b want 0/1", m_error[1], s_ready[1]);
    end
  endtask

  task automatic test_reset_midload();
    bit ok;
    int cyc, noisy;
    done_dly[0] = 3;
    send(0, NIST_PT, NIST_KEY, ok);
    repeat (5) @(negedge clk);
    total++;
    if (dword_in[0] !== 32'h00010203) begin
      bad++;
      $display("FAIL midload_word4: got %h want 00010203", dword_in[0]);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({s_ready[0], busy[0], m_valid[0], m_error[0], start_n[0], start_read_n[0]} !== 6'b100011 ||
        dword_in[0] !== 32'h0) begin
      bad++;
      $display("FAIL midload_async: got ctrl=%b dword=%h want 100011/0",
               {s_ready[0], busy[0], m_valid[0], m_error[0], start_n[0], start_read_n[0]}, dword_in[0]);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    noisy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_valid[0] || !start_n[0] || busy[0] || !start_read_n[0]) noisy++;
    end
    total++;
    if (noisy != 0) begin
      bad++;
      $display("FAIL midload_quiet: got %0d active cycles want 0", noisy);
    end
    m_ready[0] = 1'b1;
    send(0, NIST_PT, NIST_KEY, ok);
    wait_valid(0, 300, cyc, ok);
    total++;
    if (!ok || m_ct[0] !== NIST_CT || m_error[0] !== 1'b0) begin
      bad++;
      $display("FAIL midload_rerun: got valid=%b ct=%h err=%b want 1/%h/0", ok, m_ct[0], m_error[0], NIST_CT);
    end
    @(posedge clk);
    #1 m_ready[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc, sr_hi;
    bit ok;
    done_dly[0] = 3;
    m_ready[0]  = 1'b0;
    @(negedge clk);
    s_valid[0] = 1'b1;
    pt_in[0]   = NIST_PT;
    key_in[0]  = NIST_KEY;
    @(posedge clk);
    #1;
    pt_in[0]  = 128'h0;
    key_in[0] = 128'h0;
    cyc = 0;
    sr_hi = 0;
    while (!m_valid[0] && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (s_ready[0]) sr_hi++;
    end
    repeat (3) begin
      @(negedge clk);
      if (s_ready[0]) sr_hi++;
    end
    total++;
    if (sr_hi != 0 || m_ct[0] !== NIST_CT) begin
      bad++;
      $display("FAIL b2b_first: got s_ready-high=%0d ct=%h want 0/%h", sr_hi, m_ct[0], NIST_CT);
    end
    consume(0);
    total++;
    if (s_ready[0] !== 1'b1 || m_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap: got s_ready=%b valid=%b want 1/0", s_ready[0], m_valid[0]);
    end
    @(posedge clk);
    #1 s_valid[0] = 1'b0;
    total++;
    if (busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_accept: got busy=%b want 1", busy[0]);
    end
    wait_valid(0, 300, cyc, ok);
    total++;
    if (!ok || m_ct[0] !== ZERO_CT || m_error[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second: got valid=%b ct=%h err=%b want 1/%h/0", ok, m_ct[0], m_error[0], ZERO_CT);
    end
    consume(0);
  endtask

  task automatic test_random();
    logic [127:0] p, k, exp_ct;
    int u, cyc;
    bit ok;
    for (int it = 0; it < 8; it++) begin
      u = it % 2;
      p = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      exp_ct = aes_enc(p, k);
      done_dly[u] = int'($urandom_range(0, (u == 1) ? 10 : 40));
      send(u, p, k, ok);
      wait_valid(u, 400, cyc, ok);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      total++;
      if (!ok || m_ct[u] !== exp_ct || m_error[u] !== 1'b0) begin
        bad++;
        $display("FAIL random[%0d] u%0d: got valid=%b ct=%h err=%b want 1/%h/0",
                 it, u, ok, m_ct[u], m_error[u], exp_ct);
      end
      consume(u);
    end
  endtask

  initial begin
    pt_in[0] = '0; pt_in[1] = '0; key_in[0] = '0; key_in[1] = '0;
    done_dly[0] = 0; done_dly[1] = 0;
    stub_en[0] = 1'b0; stub_en[1] = 1'b0;
    for (int i = 0; i < 4; i++) stub_w[i] = 32'h0;
    test_reset();
    test_nist_load();
    test_backpressure();
    test_read_latency();
    test_watchdog();
    test_reset_midload();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no completion want summary before time limit");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire
